// File: rtl/uart_autobaud_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_autobaud_pkg
// Description : Shared types and constants for the UART auto-baud calibrator
// Revision    : 1.0 - initial release
// ============================================================================
package uart_autobaud_pkg;

    // Default parameter values for the calibrator
    localparam int DEF_CNT_W   = 20;
    localparam int DEF_DIV_W   = 16;
    localparam int DEF_MIN_BIT = 4;

    // Calibration character 0x55: five falling edges span eight bit times
    localparam int CAL_EDGES = 5;
    localparam int CAL_BITS  = 8;
    localparam int CAL_SHIFT = 3;

    // Width of the falling-edge counter (must hold CAL_EDGES)
    localparam int EDGE_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_MEASURE = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_autobaud_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_autobaud_if
// Description : Line and result signals of the UART auto-baud calibrator
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_autobaud_if #(
    parameter int DIV_W = 16
);
    logic             rx_i;
    logic             cal_start_i;
    logic             rx_o;
    logic [DIV_W-1:0] baud_div_o;
    logic             div_valid_o;
    logic             busy_o;
    logic             err_o;

    // Driver side: pad line and calibration request in, results back
    modport master (
        output rx_i,
        output cal_start_i,
        input  rx_o,
        input  baud_div_o,
        input  div_valid_o,
        input  busy_o,
        input  err_o
    );

    // Calibrator side
    modport slave (
        input  rx_i,
        input  cal_start_i,
        output rx_o,
        output baud_div_o,
        output div_valid_o,
        output busy_o,
        output err_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_autobaud_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : 2-flop synchronizer for the raw rx pad plus falling-edge pulse
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic rx_i,
    output logic rx_sync,
    output logic fall_pulse
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus one history flop; idle-high line resets to 1
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= rx_i;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rx_sync    = r_sync;
    assign fall_pulse = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_autobaud.sv
`default_nettype none
// ============================================================================
// Module      : uart_autobaud
// Description : Measures the bit period of a 0x55 calibration character and
//               reports it as a baud divisor for the downstream UART
// Revision    : 1.0 - initial release
// ============================================================================
module uart_autobaud
    import uart_autobaud_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DIV_W   = DEF_DIV_W,
    parameter int MIN_BIT = DEF_MIN_BIT
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    uart_autobaud_if.slave bus
);
    localparam logic [CNT_W-1:0]  c_cnt_max   = '1;
    localparam logic [CNT_W:0]    c_one       = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]    c_min_span  = (CNT_W+1)'(CAL_BITS * MIN_BIT);
    localparam logic [CNT_W:0]    c_round     = (CNT_W+1)'(CAL_BITS / 2);
    localparam logic [EDGE_W-1:0] c_last_edge = EDGE_W'(CAL_EDGES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [EDGE_W-1:0]  r_edges;
    logic [DIV_W-1:0]   r_div;

    logic               w_rx_sync;
    logic               w_fall;
    logic [CNT_W:0]     w_span;
    logic [CNT_W:0]     w_span_rnd;
    logic [CNT_W:0]     w_div_wide;
    logic [DIV_W-1:0]   w_div;
    logic               w_div_ovf;
    logic               w_span_short;
    logic               w_latch;
    logic               w_busy;
    logic               w_valid;
    logic               w_err;

    uart_rx_sync u_rx_sync (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .rx_i       (bus.rx_i),
        .rx_sync    (w_rx_sync),
        .fall_pulse (w_fall)
    );

    // Span is counter+1 because the counter starts at 0 one cycle after the start edge
    assign w_span       = {1'b0, r_cnt} + c_one;
    assign w_span_rnd   = w_span + c_round;
    assign w_div_wide   = w_span_rnd >> CAL_SHIFT;
    assign w_span_short = (w_span < c_min_span);

    // Fit the rounded quotient into the divisor width and flag overflow
    if (DIV_W > CNT_W) begin : g_div_wide
        assign w_div     = DIV_W'(w_div_wide);
        assign w_div_ovf = 1'b0;
    end else begin : g_div_narrow
        assign w_div     = w_div_wide[DIV_W-1:0];
        assign w_div_ovf = |w_div_wide[CNT_W:DIV_W];
    end

    // State register and measurement datapath
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_edges <= '0;
            r_div   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_ARMED && w_fall) begin
                r_cnt   <= '0;
                r_edges <= EDGE_W'(1);
            end else if (r_state == ST_MEASURE) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_fall) begin
                    r_edges <= r_edges + 1'b1;
                end
            end
            if (w_latch) begin
                r_div <= w_div;
            end
        end
    end

    // Next-state logic, divisor latch enable and state-decoded status flags
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_busy      = 1'b0;
        w_valid     = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.cal_start_i) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                w_busy = 1'b1;
                if (w_fall) w_state_nxt = ST_MEASURE;
            end
            ST_MEASURE: begin
                w_busy = 1'b1;
                // Saturation wins over a coincident edge
                if (r_cnt == c_cnt_max) begin
                    w_state_nxt = ST_ERROR;
                end else if (w_fall && r_edges == c_last_edge) begin
                    if (w_span_short || w_div_ovf) begin
                        w_state_nxt = ST_ERROR;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_latch     = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_valid = 1'b1;
                if (bus.cal_start_i) w_state_nxt = ST_ARMED;
            end
            ST_ERROR: begin
                w_err = 1'b1;
                if (bus.cal_start_i) w_state_nxt = ST_ARMED;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.rx_o        = w_rx_sync;
    assign bus.baud_div_o  = r_div;
    assign bus.div_valid_o = w_valid;
    assign bus.busy_o      = w_busy;
    assign bus.err_o       = w_err;

endmodule
`default_nettype wire

// File: doc/uart_autobaud.md
UART_AUTOBAUD -- requirements
Module: uart_autobaud

Interface
REQ-001 Parameter: CNT_W, default 20, width of the edge-to-edge cycle counter.
REQ-002 Parameter: DIV_W, default 16, width of the baud divisor output.
REQ-003 Parameter: MIN_BIT, default 4, minimum legal bit period in clock cycles.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 wb_clk_i  input  1  system clock; all logic is on its rising edge.
REQ-006 wb_rst_i  input  1  synchronous, active-high reset.
REQ-007 rx_i  input  1  raw asynchronous UART line from the pad (io_in[7]).
REQ-008 cal_start_i  input  1  single-cycle request to begin calibration.
REQ-009 rx_o  output  1  synchronized rx line, forwarded to the downstream UART macro uart_rx.
REQ-010 baud_div_o  output  DIV_W  measured cycles per bit.
REQ-011 div_valid_o  output  1  baud_div_o holds a valid result.
REQ-012 busy_o  output  1  calibration is in progress.
REQ-013 err_o  output  1  the last calibration failed.

Function
REQ-014 The block SHALL pass rx_i through a 2-flop synchronizer; rx_o SHALL equal the second flop, giving 2 cycles of latency.
REQ-015 Falling edges SHALL be detected on the synchronized line: the previous value is 1 and the current value is 0.
REQ-016 Calibration character: 0x55, sent LSB first.
- The span from the start-bit falling edge to the 5th falling edge (falling edge of bit 7) is exactly 8 bit times.
REQ-017 FSM states: IDLE, ARMED, MEASURE, DONE, ERROR.
REQ-018 IDLE/DONE/ERROR on cal_start_i SHALL transition to ARMED.
- On entry to ARMED: div_valid_o=0, err_o=0, busy_o=1.
REQ-019 ARMED: the first falling edge SHALL transition to MEASURE, clear the counter to 0, and clear the edge count to 1.
REQ-020 MEASURE SHALL increment the counter every cycle and increment the edge count on each falling edge.
- On the 5th falling edge, the block SHALL latch baud_div_o = (counter+1+4)>>3, with the result truncated to DIV_W.
- The rounding makes baud_div_o the nearest integer to the total span / 8.
- The FSM SHALL then go to DONE with div_valid_o=1 and busy_o=0.
REQ-021 DONE SHALL transition to ERROR instead if the measured span (counter+1) < 8*MIN_BIT, or if the computed divisor exceeds 2^DIV_W-1.
REQ-022 If the counter reaches 2^CNT_W-1 in MEASURE, the FSM SHALL go to ERROR (timeout) with err_o=1 and busy_o=0.
REQ-023 cal_start_i while in ARMED or MEASURE SHALL be ignored.
REQ-024 A falling edge in the same cycle as counter saturation SHALL be treated as a timeout; timeout takes priority.
REQ-025 baud_div_o SHALL hold its last valid value through ERROR and through subsequent ARMED/MEASURE.
- It SHALL change only on a successful completion.
REQ-026 rx_o forwarding SHALL be unaffected by FSM state.

Reset
REQ-027 On wb_rst_i the outputs SHALL reset as follows: synchronizer flops=1, rx_o=1, baud_div_o=0, div_valid_o=0, busy_o=0, err_o=0, FSM=IDLE, counters=0.
REQ-028 Reset asserted mid-MEASURE SHALL abort the measurement with no partial result latched.
REQ-029 Reset SHALL take priority over cal_start_i in the same cycle.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, CAL_EDGES=5, CAL_BITS=8 (shift 3), and the default parameter values.
REQ-031 One sub-module uart_rx_sync SHALL contain the 2-flop synchronizer and the falling-edge detector.
- Outputs: rx_sync, fall_pulse.
REQ-032 The baud divisor SHALL feed the UART macro's clock-divider configuration; wiring is outside this block.

Verification
REQ-033 Drive 0x55 at 16 cycles/bit after cal_start_i -> baud_div_o=16, div_valid_o=1 one cycle after the 5th edge, err_o=0.
REQ-034 Drive 0x55 at 13 cycles/bit, then at 20 cycles/bit after a second cal_start_i -> baud_div_o=13, then 20; div_valid_o drops between the runs.
REQ-035 Drive 0x55 at 2 cycles/bit with MIN_BIT=4 -> err_o=1, div_valid_o=0, and baud_div_o keeps its previous value.
REQ-036 With CNT_W=8, drive one falling edge then hold rx low -> err_o=1 after 255 cycles; the FSM then returns to ERROR and accepts cal_start_i.
REQ-037 Assert wb_rst_i after the 3rd falling edge -> all outputs at reset values next cycle; a following clean run yields the correct divisor.
REQ-038 Toggle rx_i in any state -> rx_o mirrors rx_i with 2 cycles of delay; pulse cal_start_i during MEASURE -> the measurement is unaffected.
